// File: rtl/id_stage.sv
// Decode stage of the 5-stage MIPS pipeline: IF/ID latch, 32-entry register file,
// opcode control decode, sign extension and the ID/EX pipeline register.
module id_stage #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] npc_in,
    input  logic [31:0]       instr_in,
    input  logic              stall,
    input  logic              flush,
    input  logic              wb_regwrite,
    input  logic [4:0]        wb_writereg,
    input  logic [DATA_W-1:0] wb_writedata,
    output logic [1:0]        wb_ctlout,
    output logic [2:0]        m_ctlout,
    output logic [3:0]        ex_ctlout,
    output logic [DATA_W-1:0] npcout,
    output logic [DATA_W-1:0] readdat1,
    output logic [DATA_W-1:0] readdat2,
    output logic [DATA_W-1:0] signext_out,
    output logic [4:0]        instr_2016,
    output logic [4:0]        instr_1511
);

    logic [DATA_W-1:0] ifid_npc;
    logic [31:0]       ifid_instr;
    logic [DATA_W-1:0] regs [NREGS];
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic [DATA_W-1:0] sext;
    logic [1:0]        wb_ctl;
    logic [2:0]        m_ctl;
    logic [3:0]        ex_ctl;

    assign rs = ifid_instr[25:21];
    assign rt = ifid_instr[20:16];

    // Flush has priority over stall so a taken branch always kills the fetched slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifid_npc   <= '0;
            ifid_instr <= '0;
        end else if (flush) begin
            ifid_npc   <= '0;
            ifid_instr <= '0;
        end else if (!stall) begin
            ifid_npc   <= npc_in;
            ifid_instr <= instr_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_regwrite && (wb_writereg != 5'd0)) begin
            regs[wb_writereg] <= wb_writedata;
        end
    end

    // Write-first bypass: a same-cycle write-back is visible to the decode read.
    always_comb begin
        rd_data1 = '0;
        rd_data2 = '0;
        if (rs != 5'd0) begin
            rd_data1 = (wb_regwrite && (wb_writereg == rs)) ? wb_writedata : regs[rs];
        end
        if (rt != 5'd0) begin
            rd_data2 = (wb_regwrite && (wb_writereg == rt)) ? wb_writedata : regs[rt];
        end
    end

    always_comb begin
        wb_ctl = 2'b00;
        m_ctl  = 3'b000;
        ex_ctl = 4'b0000;
        case (ifid_instr[31:26])
            6'b000000: begin wb_ctl = 2'b10; m_ctl = 3'b000; ex_ctl = 4'b1100; end
            6'b100011: begin wb_ctl = 2'b11; m_ctl = 3'b010; ex_ctl = 4'b0001; end
            6'b101011: begin wb_ctl = 2'b00; m_ctl = 3'b001; ex_ctl = 4'b0001; end
            6'b000100: begin wb_ctl = 2'b00; m_ctl = 3'b100; ex_ctl = 4'b0010; end
            default:   begin wb_ctl = 2'b00; m_ctl = 3'b000; ex_ctl = 4'b0000; end
        endcase
    end

    assign sext = {{(DATA_W-16){ifid_instr[15]}}, ifid_instr[15:0]};

    // A stall turns the ID/EX slot into a bubble by zeroing only its control fields.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_ctlout   <= '0;
            m_ctlout    <= '0;
            ex_ctlout   <= '0;
            npcout      <= '0;
            readdat1    <= '0;
            readdat2    <= '0;
            signext_out <= '0;
            instr_2016  <= '0;
            instr_1511  <= '0;
        end else begin
            wb_ctlout   <= stall ? 2'b00   : wb_ctl;
            m_ctlout    <= stall ? 3'b000  : m_ctl;
            ex_ctlout   <= stall ? 4'b0000 : ex_ctl;
            npcout      <= ifid_npc;
            readdat1    <= rd_data1;
            readdat2    <= rd_data2;
            signext_out <= sext;
            instr_2016  <= ifid_instr[20:16];
            instr_1511  <= ifid_instr[15:11];
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed decode/stall/flush/reset steps followed by random
// traffic, all checked against a behavioural model of the decode stage.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] npc_in, instr_in;
    logic        stall, flush;
    logic        wb_regwrite;
    logic [4:0]  wb_writereg;
    logic [31:0] wb_writedata;
    logic [1:0]  wb_ctlout;
    logic [2:0]  m_ctlout;
    logic [3:0]  ex_ctlout;
    logic [31:0] npcout, readdat1, readdat2, signext_out;
    logic [4:0]  instr_2016, instr_1511;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_npc, m_instr;

    logic [8:0]  e_ctl;
    logic [31:0] e_npc, e_rd1, e_rd2, e_sx;
    logic [4:0]  e_rt, e_rd;
    bit          e_dat;

    id_stage dut (
        .clk(clk), .rst(rst), .npc_in(npc_in), .instr_in(instr_in),
        .stall(stall), .flush(flush), .wb_regwrite(wb_regwrite),
        .wb_writereg(wb_writereg), .wb_writedata(wb_writedata),
        .wb_ctlout(wb_ctlout), .m_ctlout(m_ctlout), .ex_ctlout(ex_ctlout),
        .npcout(npcout), .readdat1(readdat1), .readdat2(readdat2),
        .signext_out(signext_out), .instr_2016(instr_2016), .instr_1511(instr_1511)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Control word {wb[1:0], m[2:0], ex[3:0]} by opcode.
    function automatic logic [8:0] ctl_of(input logic [5:0] op);
        case (op)
            6'd0:    return 9'b10_000_1100;
            6'h23:   return 9'b11_010_0001;
            6'h2b:   return 9'b00_001_0001;
            6'h04:   return 9'b00_100_0010;
            default: return 9'b0;
        endcase
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] r);
        if (r == 0) return 32'h0;
        if (wb_regwrite && wb_writereg == r) return wb_writedata;
        return m_regs[r];
    endfunction

    function automatic logic [31:0] sext_of(input logic [15:0] imm);
        int v;
        v = (imm >= 16'h8000) ? int'(imm) - 65536 : int'(imm);
        return 32'(v);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_npc   = 32'h0;
        m_instr = 32'h0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_wb"}, 32'(wb_ctlout), 32'h0);
        chk({tag, "_m"}, 32'(m_ctlout), 32'h0);
        chk({tag, "_ex"}, 32'(ex_ctlout), 32'h0);
        chk({tag, "_npc"}, npcout, 32'h0);
        chk({tag, "_rd1"}, readdat1, 32'h0);
        chk({tag, "_rd2"}, readdat2, 32'h0);
        chk({tag, "_sx"}, signext_out, 32'h0);
        chk({tag, "_rt"}, 32'(instr_2016), 32'h0);
        chk({tag, "_rd"}, 32'(instr_1511), 32'h0);
    endtask

    // Apply inputs for one cycle, advance the model, then compare after the edge.
    task automatic cycle(input logic [31:0] npc, input logic [31:0] ins, input logic st,
                         input logic fl, input logic we, input logic [4:0] wr,
                         input logic [31:0] wd);
        npc_in = npc; instr_in = ins; stall = st; flush = fl;
        wb_regwrite = we; wb_writereg = wr; wb_writedata = wd;
        e_ctl = st ? 9'b0 : ctl_of(m_instr[31:26]);
        e_npc = m_npc;
        e_rd1 = model_read(m_instr[25:21]);
        e_rd2 = model_read(m_instr[20:16]);
        e_sx  = sext_of(m_instr[15:0]);
        e_rt  = m_instr[20:16];
        e_rd  = m_instr[15:11];
        e_dat = !st;
        if (we && wr != 0) m_regs[wr] = wd;
        if (fl) begin
            m_npc = 32'h0; m_instr = 32'h0;
        end else if (!st) begin
            m_npc = npc; m_instr = ins;
        end
        @(posedge clk);
        #1;
        chk("wb_ctl", 32'(wb_ctlout), 32'(e_ctl[8:7]));
        chk("m_ctl", 32'(m_ctlout), 32'(e_ctl[6:4]));
        chk("ex_ctl", 32'(ex_ctlout), 32'(e_ctl[3:0]));
        if (e_dat) begin
            chk("npcout", npcout, e_npc);
            chk("readdat1", readdat1, e_rd1);
            chk("readdat2", readdat2, e_rd2);
            chk("signext", signext_out, e_sx);
            chk("instr_2016", 32'(instr_2016), 32'(e_rt));
            chk("instr_1511", 32'(instr_1511), 32'(e_rd));
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] op;
        case ($urandom_range(0, 4))
            0: op = 6'd0;
            1: op = 6'h23;
            2: op = 6'h2b;
            3: op = 6'h04;
            default: op = 6'($urandom_range(0, 63));
        endcase
        return {op, 26'($urandom)};
    endfunction

    initial begin
        rst = 1'b1;
        npc_in = 0; instr_in = 0; stall = 0; flush = 0;
        wb_regwrite = 0; wb_writereg = 0; wb_writedata = 0;
        model_reset();
        #12;
        check_all_zero("por");
        rst = 1'b0;

        // lw: r1 written and lw captured on the same edge
        cycle(32'h100, 32'h8C22_0004, 0, 0, 1, 5'd1, 32'h10);
        cycle(32'h104, 32'h0022_1820, 0, 0, 0, 5'd0, 32'h0);
        chk("lw_rd1", readdat1, 32'h10);
        chk("lw_sx", signext_out, 32'h4);
        chk("lw_rt", 32'(instr_2016), 32'd2);
        chk("lw_ctl", {23'h0, wb_ctlout, m_ctlout, ex_ctlout}, 32'b11_010_0001);
        chk("lw_npc", npcout, 32'h100);
        cycle(32'h108, 32'h1022_FFFF, 0, 0, 0, 5'd0, 32'h0);
        chk("r_rd", 32'(instr_1511), 32'd3);
        chk("r_ctl", {23'h0, wb_ctlout, m_ctlout, ex_ctlout}, 32'b10_000_1100);
        cycle(32'h10C, 32'h0020_0000, 0, 0, 0, 5'd0, 32'h0);
        chk("beq_sx", signext_out, 32'hFFFF_FFFF);
        chk("beq_ctl", {23'h0, wb_ctlout, m_ctlout, ex_ctlout}, 32'b00_100_0010);

        // bypass: r1 written while rs=1 is being decoded; then $0 write ignored
        cycle(32'h110, 32'h0000_0000, 0, 0, 1, 5'd1, 32'hAA);
        chk("bypass_rd1", readdat1, 32'hAA);
        cycle(32'h114, 32'h0000_0000, 0, 0, 1, 5'd0, 32'h55);
        chk("r0_rd1", readdat1, 32'h0);

        // stall for two cycles while instr_in changes
        cycle(32'h118, 32'h8C22_0004, 0, 0, 0, 5'd0, 32'h0);
        cycle(32'h11C, rand_instr(), 1, 0, 1, 5'd5, 32'h1234);
        chk("stall1_ctl", {23'h0, wb_ctlout, m_ctlout, ex_ctlout}, 32'h0);
        cycle(32'h120, rand_instr(), 1, 0, 0, 5'd0, 32'h0);
        chk("stall2_ctl", {23'h0, wb_ctlout, m_ctlout, ex_ctlout}, 32'h0);
        cycle(32'h124, 32'h0022_1820, 0, 0, 0, 5'd0, 32'h0);
        chk("release_ctl", {23'h0, wb_ctlout, m_ctlout, ex_ctlout}, 32'b11_010_0001);
        chk("release_npc", npcout, 32'h118);
        cycle(32'h128, 32'h0000_0000, 0, 0, 0, 5'd0, 32'h0);
        chk("after_release_ctl", {23'h0, wb_ctlout, m_ctlout, ex_ctlout}, 32'b10_000_1100);

        // flush, then flush together with stall
        cycle(32'h200, 32'h8C22_0004, 0, 1, 0, 5'd0, 32'h0);
        cycle(32'h204, 32'h8C22_0004, 0, 0, 0, 5'd0, 32'h0);
        chk("flush_npc", npcout, 32'h0);
        cycle(32'h300, 32'h8C22_0004, 1, 1, 0, 5'd0, 32'h0);
        chk("fs_ctl", {23'h0, wb_ctlout, m_ctlout, ex_ctlout}, 32'h0);
        cycle(32'h304, 32'h0000_0000, 0, 0, 0, 5'd0, 32'h0);
        chk("fs_npc", npcout, 32'h0);

        // asynchronous reset mid-operation, between clock edges
        cycle(32'h400, 32'h8C22_0004, 0, 0, 1, 5'd2, 32'hBEEF);
        #2 rst = 1'b1;
        #1 check_all_zero("async_rst");
        model_reset();
        #1 rst = 1'b0;
        cycle(32'h500, 32'h0022_1820, 0, 0, 0, 5'd0, 32'h0);
        cycle(32'h504, 32'h0000_0000, 0, 0, 0, 5'd0, 32'h0);
        chk("rst_rf_rd1", readdat1, 32'h0);
        chk("rst_rf_rd2", readdat2, 32'h0);

        for (int i = 0; i < 300; i++) begin
            cycle($urandom, rand_instr(), ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 5) == 0), 1'($urandom), 5'($urandom), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
